svm_duty_loader: RTL and testbench
==================================

Name: svm_duty_loader

Overview:
- Upstream stage of the symmetrical SVM pattern generator. It produces the four duty values d1..d4, the 8-bit input_set and the 3-bit per-phase commutation direction dir consumed by that generator and the four-step commutation stages.
- A host (the sector/duty computation or the control processor) writes values into shadow registers, then commits them as one set.
- A committed set goes live only at a switching-period boundary, signalled by the generator's interrupt output. This prevents mid-period tearing of the pattern.

Parameters:
- DW, 10, width of each duty value d1..d4.
- PERIOD, 10'd1000, maximum legal d1+d2+d3+d4, counted in pattern clock ticks.
- TICK_TIMEOUT, 16'd50000, number of clk cycles without a period tick before tick_lost asserts.

Ports:
- clk  input  1  system clock (10 ns).
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  shadow register write strobe.
- wr_addr  input  3  shadow register select.
- wr_data  input  DW  shadow write data.
- commit  input  1  single-cycle pulse: request transfer of shadow to staged.
- period_tick  input  1  interrupt from the pattern generator. It is generated on the divided clock, so it is asynchronous to clk.
- d1, d2, d3, d4  output  DW  active duty values.
- input_set  output  8  active input vector set.
- dir  output  3  active per-phase current direction.
- pending  output  1  a staged set is waiting for a period tick.
- commit_err  output  1  sticky: a commit was rejected because the duty sum exceeded PERIOD.
- overrun  output  1  sticky: a commit replaced a staged set that had not yet been applied.
- tick_lost  output  1  no period tick seen for TICK_TIMEOUT cycles.
- update_count  output  16  number of sets applied; wraps from 16'hFFFF to 0.

Behaviour:
- Reset: all shadow, staged and active registers clear to 0. All outputs are 0, including pending, commit_err, overrun, tick_lost and update_count. The synchronizer and the timeout counter also clear. Reset takes effect at any time, including mid-transfer.
- Shadow write, when wr_en=1 at a clk edge, selected by wr_addr:
  - 0 writes d1, 1 writes d2, 2 writes d3, 3 writes d4.
  - 4 writes input_set from wr_data[7:0].
  - 5 writes dir from wr_data[2:0].
  - 6 and 7 are ignored with no side effect.
  - Writes are always accepted, including while pending=1.
- Commit check: sum = d1+d2+d3+d4 over the shadow values, computed at DW+2 bits so it cannot overflow.
  - If commit=1 and sum > PERIOD: the staged set is untouched, commit_err is set (sticky until rst), and pending is unchanged.
  - If commit=1 and sum <= PERIOD: shadow is copied to staged and pending is set to 1.
  - If pending was already 1 and no tick applies in the same cycle, overrun is set (sticky). The latest commit wins.
  - A write and a commit in the same cycle: the commit sees the pre-write shadow value.
- Tick synchronizer: two flip-flops (sync1, sync2), then a prev register. tick_edge = sync2 & ~prev.
  - Latency: active outputs change on the 3rd clk rising edge after period_tick is first sampled high.
  - Only rising edges count. A held-high level gives exactly one edge.
- Apply: on tick_edge with pending=1, staged is copied to active, pending clears and update_count increments. On tick_edge with pending=0, active holds and the counter holds.
- Commit and tick_edge in the same cycle: the old staged set goes to active, then the new commit loads staged. pending stays 1 and overrun is not set.
- Timeout: the counter increments every clk and clears on tick_edge.
  - When the count reaches TICK_TIMEOUT, tick_lost is set and the counter saturates.
  - tick_lost clears on the next tick_edge.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.

Test Plan:
- Reset values: assert rst mid-run with active d1=100 -> all outputs 0 immediately (asynchronous), and they stay 0 after release until a new set is applied.
- Basic load:
  - Stimulus: write d1=100, d2=200, d3=150, d4=50, input_set=8'h5A, dir=3'b101, then commit.
  - Expected: pending=1 and outputs still 0.
  - Then raise period_tick: d1..d4, input_set and dir update on the 3rd clk edge, pending=0, update_count=1.
- Sum limit:
  - d1..d4 = 300, 300, 300, 101 (sum 1001) then commit -> commit_err=1, pending=0, and a later tick leaves active unchanged.
  - Sum exactly 1000 -> accepted.
- Overrun: commit set A (d1=10), then commit set B (d1=20) before any tick -> overrun=1. On the tick d1=20 and update_count increments by 1.
- Simultaneous commit and tick_edge: staged A is applied (d1=10), B stays staged with pending=1 and overrun=0. The next tick applies B.
- Tick loss and wrap:
  - Hold period_tick low for 50000 cycles -> tick_lost=1. The next tick clears it.
  - Force update_count to 16'hFFFF, then apply one set -> update_count=0.

Source files
------------

// File: rtl/svm_duty_loader.sv
// svm_duty_loader
// Double-buffered parameter loader for the symmetrical SVM pattern generator.
// The host fills shadow registers and commits them as one set. An accepted
// set is held in the staged bank and becomes active only on a period tick,
// so the generator never sees a half-updated pattern.
module svm_duty_loader #(
    parameter int            DW           = 10,
    parameter logic [DW-1:0] PERIOD       = 10'd1000,
    parameter logic [15:0]   TICK_TIMEOUT = 16'd50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic          period_tick,
    output logic [DW-1:0] d1,
    output logic [DW-1:0] d2,
    output logic [DW-1:0] d3,
    output logic [DW-1:0] d4,
    output logic [7:0]    input_set,
    output logic [2:0]    dir,
    output logic          pending,
    output logic          commit_err,
    output logic          overrun,
    output logic          tick_lost,
    output logic [15:0]   update_count
);

    // Shadow bank (host-written) and staged bank (committed, not yet live)
    logic [DW-1:0] sh_d1, sh_d2, sh_d3, sh_d4;
    logic [7:0]    sh_iset;
    logic [2:0]    sh_dir;
    logic [DW-1:0] st_d1, st_d2, st_d3, st_d4;
    logic [7:0]    st_iset;
    logic [2:0]    st_dir;

    // Tick synchronizer and edge detector
    logic sync1, sync2, prev;
    logic tick_edge;

    // Timeout counter
    logic [15:0] tmo_cnt;

    // Commit qualification
    logic [DW+1:0] shadow_sum;
    logic          sum_ok;
    logic          accept;
    logic          apply;

    // Two guard bits keep the four-way sum from overflowing.
    assign shadow_sum = {2'b00, sh_d1} + {2'b00, sh_d2} + {2'b00, sh_d3} + {2'b00, sh_d4};
    assign sum_ok     = (shadow_sum <= {2'b00, PERIOD});
    assign accept     = commit & sum_ok;
    assign tick_edge  = sync2 & ~prev;
    assign apply      = tick_edge & pending;

    // Shadow register writes; addresses 6 and 7 fall through untouched
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values; this is what lets a same-cycle commit see
        // the old shadow contents while the write lands.
        if (rst) begin
            sh_d1   <= '0;
            sh_d2   <= '0;
            sh_d3   <= '0;
            sh_d4   <= '0;
            sh_iset <= '0;
            sh_dir  <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                3'd0:    sh_d1   <= wr_data;
                3'd1:    sh_d2   <= wr_data;
                3'd2:    sh_d3   <= wr_data;
                3'd3:    sh_d4   <= wr_data;
                3'd4:    sh_iset <= wr_data[7:0];
                3'd5:    sh_dir  <= wr_data[2:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer for the divided-clock interrupt, plus edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= period_tick;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Staged bank loads on every accepted commit; the latest commit wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_d1   <= '0;
            st_d2   <= '0;
            st_d3   <= '0;
            st_d4   <= '0;
            st_iset <= '0;
            st_dir  <= '0;
        end else if (accept) begin
            st_d1   <= sh_d1;
            st_d2   <= sh_d2;
            st_d3   <= sh_d3;
            st_d4   <= sh_d4;
            st_iset <= sh_iset;
            st_dir  <= sh_dir;
        end
    end

    // Active bank follows staged only at a period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            d4        <= '0;
            input_set <= '0;
            dir       <= '0;
        end else if (apply) begin
            d1        <= st_d1;
            d2        <= st_d2;
            d3        <= st_d3;
            d4        <= st_d4;
            input_set <= st_iset;
            dir       <= st_dir;
        end
    end

    // Handshake and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            commit_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // A commit in the same cycle as an apply re-arms pending.
            if (accept)
                pending <= 1'b1;
            else if (apply)
                pending <= 1'b0;

            if (commit && !sum_ok)
                commit_err <= 1'b1;

            // Replacing a staged set is only an overrun if it was never applied.
            if (accept && pending && !tick_edge)
                overrun <= 1'b1;
        end
    end

    // Applied-set counter; assigned every cycle so it always reflects its own
    // previous value plus the apply event, and wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            update_count <= '0;
        else
            update_count <= update_count + 16'(apply);
    end

    // Watchdog on the period tick: saturates at the limit and flags tick_lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt   <= '0;
            tick_lost <= 1'b0;
        end else if (tick_edge) begin
            tmo_cnt   <= '0;
            tick_lost <= 1'b0;
        end else if (tmo_cnt != TICK_TIMEOUT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TICK_TIMEOUT - 16'd1)
                tick_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_svm_duty_loader.sv
// Self-checking bench for svm_duty_loader: directed scenarios followed by
// random traffic, every cycle compared with a transaction-level model.
module tb_svm_duty_loader;

    localparam int DW  = 10;
    localparam int PER = 1000;
    localparam int TMO = 50000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic          period_tick = 1'b0;
    logic [DW-1:0] d1, d2, d3, d4;
    logic [7:0]    input_set;
    logic [2:0]    dir;
    logic          pending, commit_err, overrun, tick_lost;
    logic [15:0]   update_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: register banks as plain arrays
    // index 0..3 = d1..d4, 4 = input_set, 5 = dir
    int m_sh[6];
    int m_st[6];
    int m_ac[6];
    bit m_pend, m_cerr, m_ovr, m_lost;
    int m_cnt;
    int m_since;
    bit h1, h2, h3;   // period_tick as sampled 1, 2 and 3 edges ago

    svm_duty_loader dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .period_tick  (period_tick),
        .d1           (d1),
        .d2           (d2),
        .d3           (d3),
        .d4           (d4),
        .input_set    (input_set),
        .dir          (dir),
        .pending      (pending),
        .commit_err   (commit_err),
        .overrun      (overrun),
        .tick_lost    (tick_lost),
        .update_count (update_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sh[i] = 0;
            m_st[i] = 0;
            m_ac[i] = 0;
        end
        m_pend  = 0;
        m_cerr  = 0;
        m_ovr   = 0;
        m_lost  = 0;
        m_cnt   = 0;
        m_since = 0;
        h1 = 0;
        h2 = 0;
        h3 = 0;
    endtask

    // One clock edge of the spec behaviour: apply, then commit, then write.
    task automatic model_edge();
        bit tick;
        int sum;
        int wd;
        if (rst) begin
            model_reset();
            return;
        end
        // A tick takes effect on the 3rd edge after the first high sample.
        tick = h2 && !h3;
        h3 = h2;
        h2 = h1;
        h1 = period_tick;

        if (tick && m_pend) begin
            m_ac   = m_st;
            m_pend = 0;
            m_cnt  = (m_cnt + 1) % 65536;
        end

        sum = m_sh[0] + m_sh[1] + m_sh[2] + m_sh[3];
        if (commit) begin
            if (sum > PER) begin
                m_cerr = 1;
            end else begin
                if (m_pend && !tick)
                    m_ovr = 1;
                m_st   = m_sh;
                m_pend = 1;
            end
        end

        if (wr_en) begin
            wd = int'(wr_data);
            case (int'(wr_addr))
                0, 1, 2, 3: m_sh[wr_addr] = wd % 1024;
                4:          m_sh[4] = wd % 256;
                5:          m_sh[5] = wd % 8;
                default:    ;
            endcase
        end

        if (tick) begin
            m_since = 0;
            m_lost  = 0;
        end else if (m_since < TMO) begin
            m_since++;
            if (m_since == TMO)
                m_lost = 1;
        end
    endtask

    task automatic compare_all();
        check("d1", d1, m_ac[0]);
        check("d2", d2, m_ac[1]);
        check("d3", d3, m_ac[2]);
        check("d4", d4, m_ac[3]);
        check("input_set", input_set, m_ac[4]);
        check("dir", dir, m_ac[5]);
        check("pending", pending, m_pend);
        check("commit_err", commit_err, m_cerr);
        check("overrun", overrun, m_ovr);
        check("tick_lost", tick_lost, m_lost);
        check("update_count", update_count, m_cnt);
    endtask

    // Inputs change only just after a falling edge; outputs compared there too.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = DW'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    task automatic load_set(input int a, input int b, input int c, input int d,
                            input int iset, input int dr);
        wr(0, a);
        wr(1, b);
        wr(2, c);
        wr(3, d);
        wr(4, iset);
        wr(5, dr);
    endtask

    task automatic tick_pulse();
        period_tick = 1'b1;
        repeat (3) step();
        period_tick = 1'b0;
        step();
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for clk.
    task automatic async_reset();
        wr_en = 1'b0;
        commit = 1'b0;
        period_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_d1", d1, 0);
        check("async_rst_iset", input_set, 0);
        check("async_rst_pending", pending, 0);
        check("async_rst_count", update_count, 0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        step();

        // Basic load and 3-edge tick latency
        load_set(100, 200, 150, 50, 8'h5A, 3'b101);
        do_commit();
        check("basic_pending", pending, 1);
        check("basic_d1_hold", d1, 0);
        period_tick = 1'b1;
        step();
        step();
        check("lat_d1_pre", d1, 0);
        step();
        check("lat_d1", d1, 100);
        check("lat_d2", d2, 200);
        check("lat_d3", d3, 150);
        check("lat_d4", d4, 50);
        check("lat_iset", input_set, 8'h5A);
        check("lat_dir", dir, 3'b101);
        check("lat_pending", pending, 0);
        check("lat_count", update_count, 1);
        // Held-high level must not produce a second apply
        load_set(1, 2, 3, 4, 8'h11, 3'b010);
        do_commit();
        repeat (4) step();
        period_tick = 1'b0;
        step();
        check("held_high_d1", d1, 100);
        check("held_high_count", update_count, 1);

        // Asynchronous reset with an active set, and it stays clear
        async_reset();
        repeat (3) step();
        check("post_rst_d1", d1, 0);

        // Sum limit: 1001 rejected, write+commit sees old shadow, 1000 accepted
        load_set(300, 300, 300, 101, 8'hC3, 3'b011);
        do_commit();
        check("sum_err", commit_err, 1);
        check("sum_err_pending", pending, 0);
        tick_pulse();
        check("sum_err_d1", d1, 0);
        wr_en = 1'b1;
        wr_addr = 3'd3;
        wr_data = DW'(100);
        commit = 1'b1;
        step();
        wr_en = 1'b0;
        commit = 1'b0;
        check("wr_commit_pre", pending, 0);
        do_commit();
        check("sum_ok_pending", pending, 1);
        tick_pulse();
        check("sum_ok_d1", d1, 300);
        check("sum_ok_d4", d4, 100);

        // Overrun: B replaces unapplied A
        wr(0, 10);
        wr(3, 0);
        do_commit();
        wr(0, 20);
        do_commit();
        check("overrun_set", overrun, 1);
        tick_pulse();
        check("overrun_d1", d1, 20);
        check("overrun_count", update_count, 2);

        // Commit in the same cycle as the tick edge
        async_reset();
        wr(0, 10);
        do_commit();
        wr(0, 20);
        period_tick = 1'b1;
        step();
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        period_tick = 1'b0;
        check("simul_d1", d1, 10);
        check("simul_pending", pending, 1);
        check("simul_overrun", overrun, 0);
        step();
        tick_pulse();
        check("simul_next_d1", d1, 20);
        check("simul_next_count", update_count, 2);

        // Tick loss: watchdog fires after exactly the timeout count
        async_reset();
        repeat (TMO - 2) step();
        check("tmo_before", tick_lost, 0);
        step();
        check("tmo_at", tick_lost, 1);
        repeat (5) step();
        tick_pulse();
        check("tmo_cleared", tick_lost, 0);

        // Counter wrap from 16'hFFFF
        force dut.update_count = 16'hFFFF;
        m_cnt = 65535;
        step();
        release dut.update_count;
        step();
        check("wrap_pre", update_count, 16'hFFFF);
        wr(0, 7);
        do_commit();
        tick_pulse();
        check("wrap_zero", update_count, 0);
        check("wrap_d1", d1, 7);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                wr_data = DW'($urandom);
            else
                wr_data = DW'($urandom_range(0, 300));
            commit = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0)
                period_tick = ~period_tick;
            step();
        end
        wr_en = 1'b0;
        commit = 1'b0;
        period_tick = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
